// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_if
// Purpose  : Memory handshake and datapath control bundle for multicycle_control.
// Revision : 1.0
// ============================================================================
interface multicycle_control_if #(
  parameter int INSTR_WIDTH  = 16,
  parameter int ALU_OP_WIDTH = 4,
  parameter int RETIRE_WIDTH = 16
);
  logic [INSTR_WIDTH-1:0]  mem_data;
  logic                    mem_ready;
  logic                    alu_zero;
  logic                    resume;
  logic                    mem_req;
  logic                    mem_we;
  logic                    ir_load;
  logic                    pc_write_en;
  logic                    pc_src_branch;
  logic                    reg_write_en;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic                    halted;
  logic [RETIRE_WIDTH-1:0] retired_count;

  // The control unit drives the datapath/memory strobes.
  modport master (
    input  mem_data, mem_ready, alu_zero, resume,
    output mem_req, mem_we, ir_load, pc_write_en, pc_src_branch,
           reg_write_en, alu_op, halted, retired_count
  );

  // Memory / datapath side.
  modport slave (
    output mem_data, mem_ready, alu_zero, resume,
    input  mem_req, mem_we, ir_load, pc_write_en, pc_src_branch,
           reg_write_en, alu_op, halted, retired_count
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control FSM.
// Revision : 1.0
// ============================================================================
module multicycle_control #(
  parameter int INSTR_WIDTH  = 16,
  parameter int OP_WIDTH     = 4,
  parameter int ALU_OP_WIDTH = 4,
  parameter int RETIRE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  localparam logic [OP_WIDTH-1:0] c_op_halt = OP_WIDTH'(4'h0);
  localparam logic [OP_WIDTH-1:0] c_op_add  = OP_WIDTH'(4'h1);
  localparam logic [OP_WIDTH-1:0] c_op_sub  = OP_WIDTH'(4'h2);
  localparam logic [OP_WIDTH-1:0] c_op_and  = OP_WIDTH'(4'h3);
  localparam logic [OP_WIDTH-1:0] c_op_or   = OP_WIDTH'(4'h4);
  localparam logic [OP_WIDTH-1:0] c_op_lw   = OP_WIDTH'(4'h8);
  localparam logic [OP_WIDTH-1:0] c_op_sw   = OP_WIDTH'(4'h9);
  localparam logic [OP_WIDTH-1:0] c_op_beq  = OP_WIDTH'(4'hA);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [OP_WIDTH-1:0]     op_q, op_d;
  logic [ALU_OP_WIDTH-1:0] alu_op_q, alu_op_d;
  logic                    ir_load_q, ir_load_d;
  logic                    pc_write_en_q, pc_write_en_d;
  logic                    pc_src_branch_q, pc_src_branch_d;
  logic                    reg_write_en_q, reg_write_en_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;

  // Only the opcode is needed for sequencing; the operand fields belong to the datapath.
  logic unused_operand_bits;
  assign unused_operand_bits = ^bus.mem_data[INSTR_WIDTH-OP_WIDTH-1:0];

  function automatic logic [ALU_OP_WIDTH-1:0] alu_op_for(input logic [OP_WIDTH-1:0] op);
    logic [ALU_OP_WIDTH-1:0] res;
    res = '0;
    case (op)
      c_op_add, c_op_sub, c_op_and, c_op_or: res = ALU_OP_WIDTH'(op);
      c_op_lw, c_op_sw:                      res = ALU_OP_WIDTH'(c_op_add);
      c_op_beq:                              res = ALU_OP_WIDTH'(c_op_sub);
      default:                               res = '0;
    endcase
    return res;
  endfunction

  function automatic logic is_alu_op(input logic [OP_WIDTH-1:0] op);
    return (op == c_op_add) || (op == c_op_sub) || (op == c_op_and) || (op == c_op_or);
  endfunction

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    alu_op_d        = alu_op_q;
    ir_load_d       = 1'b0;
    pc_write_en_d   = 1'b0;
    pc_src_branch_d = 1'b0;
    reg_write_en_d  = 1'b0;
    retired_d       = retired_q;

    case (state_q)
      ST_FETCH: begin
        if (bus.mem_ready) begin
          op_d      = bus.mem_data[INSTR_WIDTH-1 -: OP_WIDTH];
          ir_load_d = 1'b1;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op_q == c_op_halt) begin
          state_d = ST_HALTED;
        end else begin
          // Registered here so alu_op is stable for the whole EXECUTE cycle.
          alu_op_d = alu_op_for(op_q);
          state_d  = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (is_alu_op(op_q)) begin
          state_d = ST_WRITEBACK;
        end else if ((op_q == c_op_lw) || (op_q == c_op_sw)) begin
          state_d = ST_MEM;
        end else if (op_q == c_op_beq) begin
          pc_write_en_d   = 1'b1;
          pc_src_branch_d = bus.alu_zero;
          state_d         = ST_FETCH;
        end else begin
          pc_write_en_d = 1'b1;
          state_d       = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          if (op_q == c_op_sw) begin
            pc_write_en_d = 1'b1;
            state_d       = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: begin
        reg_write_en_d = 1'b1;
        pc_write_en_d  = 1'b1;
        state_d        = ST_FETCH;
      end
      ST_HALTED: begin
        if (bus.resume) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (pc_write_en_d) begin
      retired_d = retired_q + RETIRE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_FETCH;
      op_q            <= '0;
      alu_op_q        <= '0;
      ir_load_q       <= 1'b0;
      pc_write_en_q   <= 1'b0;
      pc_src_branch_q <= 1'b0;
      reg_write_en_q  <= 1'b0;
      retired_q       <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      alu_op_q        <= alu_op_d;
      ir_load_q       <= ir_load_d;
      pc_write_en_q   <= pc_write_en_d;
      pc_src_branch_q <= pc_src_branch_d;
      reg_write_en_q  <= reg_write_en_d;
      retired_q       <= retired_d;
    end
  end

  // Request strobes are decoded from state, gated so they drop the moment reset rises.
  assign bus.mem_req       = ~reset & ((state_q == ST_FETCH) | (state_q == ST_MEM));
  assign bus.mem_we        = ~reset & (state_q == ST_MEM) & (op_q == c_op_sw);
  assign bus.halted        = (state_q == ST_HALTED);
  assign bus.ir_load       = ir_load_q;
  assign bus.pc_write_en   = pc_write_en_q;
  assign bus.pc_src_branch = pc_src_branch_q;
  assign bus.reg_write_en  = reg_write_en_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.retired_count = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Randomized self-checking bench with an instruction-level timing model.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control;

  typedef struct {
    logic [3:0] op;
    int         wf;    // cycles FETCH waits before mem_ready
    int         wm;    // cycles MEM waits before mem_ready
    logic       zero;  // alu_zero presented in EXECUTE
    int         rw;    // cycles HALTED waits before resume
  } instr_t;

  logic        clk;
  logic        reset;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        alu_zero;
  logic        resume;

  int vecs;
  int miscmp;

  int         ret_model;
  logic [3:0] alu_model;
  logic       pend_pc, pend_src, pend_reg;

  multicycle_control_if #(.INSTR_WIDTH(16), .ALU_OP_WIDTH(4), .RETIRE_WIDTH(16)) if_a ();
  multicycle_control_if #(.INSTR_WIDTH(16), .ALU_OP_WIDTH(4), .RETIRE_WIDTH(4))  if_b ();

  assign if_a.mem_data  = mem_data;
  assign if_a.mem_ready = mem_ready;
  assign if_a.alu_zero  = alu_zero;
  assign if_a.resume    = resume;
  assign if_b.mem_data  = mem_data;
  assign if_b.mem_ready = mem_ready;
  assign if_b.alu_zero  = alu_zero;
  assign if_b.resume    = resume;

  multicycle_control #(.INSTR_WIDTH(16), .OP_WIDTH(4), .ALU_OP_WIDTH(4), .RETIRE_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  multicycle_control #(.INSTR_WIDTH(16), .OP_WIDTH(4), .ALU_OP_WIDTH(4), .RETIRE_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic instr_t mk(input logic [3:0] op, input int wf, input int wm,
                                input logic zero, input int rw);
    instr_t t;
    t.op = op; t.wf = wf; t.wm = wm; t.zero = zero; t.rw = rw;
    return t;
  endfunction

  function automatic logic [3:0] alu_map(input logic [3:0] op);
    if (op >= 4'h1 && op <= 4'h4) return op;
    if (op == 4'h8 || op == 4'h9) return 4'h1;
    if (op == 4'hA) return 4'h2;
    return 4'h0;
  endfunction

  function automatic logic [10:0] bundle_a();
    return {if_a.mem_req, if_a.mem_we, if_a.ir_load, if_a.pc_write_en, if_a.pc_src_branch,
            if_a.reg_write_en, if_a.halted, if_a.alu_op};
  endfunction

  function automatic logic [10:0] bundle_b();
    return {if_b.mem_req, if_b.mem_we, if_b.ir_load, if_b.pc_write_en, if_b.pc_src_branch,
            if_b.reg_write_en, if_b.halted, if_b.alu_op};
  endfunction

  task automatic model_reset();
    ret_model = 0;
    alu_model = 4'h0;
    pend_pc   = 1'b0;
    pend_src  = 1'b0;
    pend_reg  = 1'b0;
  endtask

  // Runs a program and compares every cycle against the instruction timing model.
  task automatic play(input instr_t prog[$]);
    logic [10:0] e_bus;
    foreach (prog[i]) begin
      instr_t t;
      bit is_halt, is_alu, is_lw, is_sw, is_beq, is_mem;
      int len;
      t       = prog[i];
      is_halt = (t.op == 4'h0);
      is_alu  = (t.op >= 4'h1 && t.op <= 4'h4);
      is_lw   = (t.op == 4'h8);
      is_sw   = (t.op == 4'h9);
      is_beq  = (t.op == 4'hA);
      is_mem  = is_lw || is_sw;
      if (is_halt)     len = t.wf + 3 + t.rw;
      else if (is_alu) len = t.wf + 4;
      else if (is_lw)  len = t.wf + 5 + t.wm;
      else if (is_sw)  len = t.wf + 4 + t.wm;
      else             len = t.wf + 3;
      for (int k = 0; k < len; k++) begin
        logic e_req, e_we, e_ir, e_pc, e_src, e_reg, e_halt;
        mem_ready = 1'($urandom_range(0, 1));
        mem_data  = 16'($urandom);
        alu_zero  = 1'($urandom_range(0, 1));
        resume    = 1'($urandom_range(0, 1));
        if (k < t.wf) mem_ready = 1'b0;
        if (k == t.wf) begin
          mem_ready = 1'b1;
          mem_data  = {t.op, 12'($urandom)};
        end
        if (is_mem && k >= t.wf + 3 && k < t.wf + 3 + t.wm) mem_ready = 1'b0;
        if (is_mem && k == t.wf + 3 + t.wm) mem_ready = 1'b1;
        if (!is_halt && k == t.wf + 2) alu_zero = t.zero;
        if (is_halt && k >= t.wf + 2) resume = (k == t.wf + 2 + t.rw);

        e_req  = (k <= t.wf) || (is_mem && k >= t.wf + 3 && k <= t.wf + 3 + t.wm);
        e_we   = is_sw && k >= t.wf + 3 && k <= t.wf + 3 + t.wm;
        e_ir   = (k == t.wf + 1);
        e_pc   = (k == 0) && pend_pc;
        e_src  = (k == 0) && pend_src;
        e_reg  = (k == 0) && pend_reg;
        e_halt = is_halt && (k >= t.wf + 2);
        if (k == 0 && pend_pc) ret_model++;
        if (k == 0) begin
          pend_pc = 1'b0; pend_src = 1'b0; pend_reg = 1'b0;
        end
        if (!is_halt && k == t.wf + 2) alu_model = alu_map(t.op);
        e_bus = {e_req, e_we, e_ir, e_pc, e_src, e_reg, e_halt, alu_model};

        @(negedge clk);
        vecs++;
        if (bundle_a() !== e_bus) begin
          miscmp++;
          $display("FAIL ctrl_a op=%h k=%0d got=%03h exp=%03h", t.op, k, bundle_a(), e_bus);
        end
        vecs++;
        if (bundle_b() !== e_bus) begin
          miscmp++;
          $display("FAIL ctrl_b op=%h k=%0d got=%03h exp=%03h", t.op, k, bundle_b(), e_bus);
        end
        vecs++;
        if (if_a.retired_count !== 16'(ret_model)) begin
          miscmp++;
          $display("FAIL retired_a op=%h k=%0d got=%0d exp=%0d", t.op, k, if_a.retired_count, 16'(ret_model));
        end
        vecs++;
        if (if_b.retired_count !== 4'(ret_model)) begin
          miscmp++;
          $display("FAIL retired_b op=%h k=%0d got=%0d exp=%0d", t.op, k, if_b.retired_count, 4'(ret_model));
        end
        @(posedge clk);
        #1;
      end
      pend_pc  = !is_halt;
      pend_src = is_beq && t.zero;
      pend_reg = is_alu || is_lw;
    end
    // One idle FETCH cycle to observe the last instruction's retirement pulses.
    mem_ready = 1'b0;
    mem_data  = 16'($urandom);
    alu_zero  = 1'($urandom_range(0, 1));
    resume    = 1'($urandom_range(0, 1));
    if (pend_pc) ret_model++;
    e_bus = {1'b1, 1'b0, 1'b0, pend_pc, pend_src, pend_reg, 1'b0, alu_model};
    pend_pc = 1'b0; pend_src = 1'b0; pend_reg = 1'b0;
    @(negedge clk);
    vecs++;
    if (bundle_a() !== e_bus) begin
      miscmp++;
      $display("FAIL tail_a got=%03h exp=%03h", bundle_a(), e_bus);
    end
    vecs++;
    if (if_a.retired_count !== 16'(ret_model)) begin
      miscmp++;
      $display("FAIL tail_retired_a got=%0d exp=%0d", if_a.retired_count, 16'(ret_model));
    end
    vecs++;
    if (if_b.retired_count !== 4'(ret_model)) begin
      miscmp++;
      $display("FAIL tail_retired_b got=%0d exp=%0d", if_b.retired_count, 4'(ret_model));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_data  = 16'($urandom);
      @(negedge clk);
      vecs++;
      if (bundle_a() !== 11'h0 || bundle_b() !== 11'h0) begin
        miscmp++;
        $display("FAIL reset_outputs got_a=%03h got_b=%03h exp=000", bundle_a(), bundle_b());
      end
      vecs++;
      if (if_a.retired_count !== 16'h0 || if_b.retired_count !== 4'h0) begin
        miscmp++;
        $display("FAIL reset_retired got_a=%0d got_b=%0d exp=0", if_a.retired_count, if_b.retired_count);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    mem_ready = 1'b0; mem_data = 16'h0; alu_zero = 1'b0; resume = 1'b0;
    apply_reset();
  endtask

  task automatic test_alu_add();
    instr_t p[$];
    p.push_back(mk(4'h1, 0, 0, 1'b0, 0));
    play(p);
    vecs++;
    if (if_a.retired_count !== 16'd1) begin
      miscmp++;
      $display("FAIL add_retired got=%0d exp=1", if_a.retired_count);
    end
  endtask

  task automatic test_halt_resume();
    instr_t p[$];
    p.push_back(mk(4'h0, 0, 0, 1'b0, 2));
    p.push_back(mk(4'hF, 1, 0, 1'b0, 0));
    play(p);
    vecs++;
    if (if_a.retired_count !== 16'd2) begin
      miscmp++;
      $display("FAIL halt_retired got=%0d exp=2", if_a.retired_count);
    end
  endtask

  task automatic test_sw_wait();
    instr_t p[$];
    p.push_back(mk(4'h9, 1, 3, 1'b0, 0));
    play(p);
    vecs++;
    if (if_a.retired_count !== 16'd3) begin
      miscmp++;
      $display("FAIL sw_retired got=%0d exp=3", if_a.retired_count);
    end
  endtask

  task automatic test_beq();
    instr_t p[$];
    p.push_back(mk(4'hA, 0, 0, 1'b1, 0));
    p.push_back(mk(4'hA, 0, 0, 1'b0, 0));
    play(p);
    vecs++;
    if (if_a.retired_count !== 16'd5) begin
      miscmp++;
      $display("FAIL beq_retired got=%0d exp=5", if_a.retired_count);
    end
  endtask

  task automatic test_reset_mid();
    instr_t p[$];
    mem_ready = 1'b1; mem_data = 16'h8123; alu_zero = 1'b0; resume = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    vecs++;
    if (if_a.ir_load !== 1'b1) begin
      miscmp++;
      $display("FAIL lw_ir_load got=%b exp=1", if_a.ir_load);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vecs++;
    if (if_a.alu_op !== 4'h1) begin
      miscmp++;
      $display("FAIL lw_alu_op got=%h exp=1", if_a.alu_op);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vecs++;
    if ({if_a.mem_req, if_a.mem_we} !== 2'b10) begin
      miscmp++;
      $display("FAIL lw_mem_phase got=%b exp=10", {if_a.mem_req, if_a.mem_we});
    end
    #1 reset = 1'b1;
    #1;
    vecs++;
    if (bundle_a() !== 11'h0 || bundle_b() !== 11'h0) begin
      miscmp++;
      $display("FAIL midreset_outputs got_a=%03h got_b=%03h exp=000", bundle_a(), bundle_b());
    end
    vecs++;
    if (if_a.retired_count !== 16'h0 || if_b.retired_count !== 4'h0) begin
      miscmp++;
      $display("FAIL midreset_retired got_a=%0d got_b=%0d exp=0", if_a.retired_count, if_b.retired_count);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    p.push_back(mk(4'h1, 0, 0, 1'b0, 0));
    p.push_back(mk(4'h8, 0, 2, 1'b0, 0));
    play(p);
    vecs++;
    if (if_a.retired_count !== 16'd2) begin
      miscmp++;
      $display("FAIL midreset_after got=%0d exp=2", if_a.retired_count);
    end
  endtask

  task automatic test_random();
    instr_t p[$];
    for (int i = 0; i < 150; i++) begin
      p.push_back(mk(4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3)));
    end
    play(p);
  endtask

  task automatic test_wrap();
    instr_t p[$];
    @(posedge clk); #1;
    apply_reset();
    for (int i = 0; i < 17; i++) p.push_back(mk(4'hF, 0, 0, 1'b0, 0));
    play(p);
    vecs++;
    if (if_b.retired_count !== 4'd1) begin
      miscmp++;
      $display("FAIL wrap_retired_b got=%0d exp=1", if_b.retired_count);
    end
    vecs++;
    if (if_a.retired_count !== 16'd17) begin
      miscmp++;
      $display("FAIL wrap_retired_a got=%0d exp=17", if_a.retired_count);
    end
  endtask

  initial begin
    vecs   = 0;
    miscmp = 0;
    reset  = 1'b1;
    model_reset();
    test_reset();
    test_alu_add();
    test_halt_resume();
    test_sw_wait();
    test_beq();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
`default_nettype wire
